alu_iterative_md: RTL
=====================

// Module: alu_iterative_md
// PURPOSE
//  Parametrised ALU with an iterative multiply/divide datapath for the RISC-V core (RV32IM-style ops).
//  Single-cycle integer ops complete in 1 cycle; MUL/DIV/REM run an XLEN-cycle shift-add / restoring loop.
//  Uses a start/ready/done handshake with registered result and Z/N/V/C flags.
//  Sits in the execute stage; the control unit stalls the pipeline while ready=0.
// PARAMETERS
//  XLEN       32  datapath width; must be a power of two and >= 8
//  MULDIV_EN  1   0: ops 1010-1111 are illegal (1-cycle, result 0, illegal=1)
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     request; accepted only when ready=1
//  ALUControl   in   4     op code, sampled on accept
//  a, b         in   XLEN  operands, sampled on accept
//  ready        out  1     1 only in state IDLE
//  done         out  1     1-cycle pulse when result/flags become valid
//  result       out  XLEN  registered result; holds until the next done
//  z, n, v, c   out  1     registered flags; update only with done
//  illegal      out  1     registered; 1 for a disabled op; updates with done
// BEHAVIOUR
//  Ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL,
//    1000 SRL, 1001 SRA, 1010 MUL (low XLEN), 1011 MULHU, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
//  Shift amount is b[$clog2(XLEN)-1:0]. SLT/SLTU return a zero-extended 0/1.
//  FSM IDLE -> DONE for a simple op or fast-path case. IDLE -> CALC for an iterative op.
//    CALC -> DONE when the count reaches XLEN. DONE -> IDLE unconditionally.
//  Latency (start cycle = T): simple/fast-path op: done at T+1. Iterative op: done at T+XLEN+1.
//    Next accept is possible at done cycle + 1.
//  start while ready=0 is ignored: no queueing, and operands are not resampled.
//  Flags:
//    z = (result==0); n = result[XLEN-1].
//    c = carry out of a+b+cin for ADD and SUB; for SUB, c=1 means no borrow. c=0 for other ops.
//    v = signed overflow for ADD/SUB only, else 0.
//  MUL/MULHU: unsigned shift-add on a 2*XLEN accumulator; MUL takes the low half, MULHU the high half.
//  DIV/REM: restoring division on operand magnitudes. Quotient sign = a^b sign; remainder sign = a sign.
//  Fast path, decided at accept, 1 cycle, no CALC:
//    divide-by-zero (b==0): DIV/DIVU -> all ones; REM/REMU -> a.
//    signed overflow (a=-2^(XLEN-1), b=-1): DIV -> a; REM -> 0.
//  Reset (rst=1 at a clock edge): state IDLE, result=0, z=1, n=v=c=0, done=0, illegal=0, ready=1
//    from the next cycle. Reset during CALC aborts the operation; no done is produced.
//  result/flags are never visible mid-computation; internal accumulators are private.
// STRUCTURE
//  Package alu_pkg: localparams for the 4-bit op codes and FSM state encodings (IDLE, CALC, DONE).
//  Sub-module alu_seq_muldiv (XLEN):
//    start/mode/a/b in; busy/done/lo/hi out.
//    Owns the counter, the 2*XLEN accumulator, and sign correction.
//    Top level owns the combinational ops, fast-path detection, flags and the handshake FSM.
// TESTING
//  1 ADD 0x7FFFFFFF+1 -> done at T+1, result 0x80000000, v=1, n=1, c=0, z=0.
//  2 SUB 5-5 -> result 0, z=1, c=1. SUB 0-1 -> 0xFFFFFFFF, c=0, n=1.
//  3 MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE at T+33. MULHU of the same operands -> 0x00000001.
//    ready=0 during T+1..T+33.
//  4 DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1. DIVU 100/0 -> 0xFFFFFFFF at T+1.
//    DIV 0x80000000/-1 -> 0x80000000 at T+1.
//  5 start pulses during CALC with changed a/b -> ignored; the original result is returned at T+33.
//  6 rst asserted at T+10 of a DIV -> no done pulse; result=0, z=1; a new ADD is accepted the cycle after reset is released.

Source files
------------

// File: rtl/alu_iterative_md_pkg.sv
// Purpose : shared op codes, FSM encodings and sequencer modes for the iterative ALU.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: OP_* 4-bit op codes, state_t (IDLE/CALC/DONE), md_mode_t, is_md_op().
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_CALC_ENC = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    CALC = ST_CALC_ENC,
    DONE = ST_DONE_ENC
  } state_t;

  // Sequencer flavour: unsigned multiply, signed divide, unsigned divide.
  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVS = 2'b01,
    MD_DIVU = 2'b10
  } md_mode_t;

  // Ops 1010..1111 belong to the multiply/divide group.
  function automatic logic is_md_op(input logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction

endpackage

// File: rtl/alu_iterative_md_if.sv
// Purpose : request/response bundle between the control unit and the iterative ALU.
// Latency : n/a (wiring only).
// Backpressure: requester may only have start honoured while ready=1.
// Ports   : start/ALUControl/a/b (request), ready/done/result/z/n/v/c/illegal (response).
interface alu_iterative_md_if #(
  parameter int XLEN = 32
);
  import alu_pkg::*;

  logic            start;
  logic [3:0]      ALUControl;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;
  logic            z;
  logic            n;
  logic            v;
  logic            c;
  logic            illegal;

  // Requester side (control unit / execute stage).
  modport master (
    output start, ALUControl, a, b,
    input  ready, done, result, z, n, v, c, illegal
  );

  // ALU side.
  modport slave (
    input  start, ALUControl, a, b,
    output ready, done, result, z, n, v, c, illegal
  );

endinterface

// File: rtl/alu_iterative_md_seq_muldiv.sv
// Purpose : XLEN-step shift-add multiplier / restoring divider with sign correction.
// Latency : done asserted XLEN cycles after start; lo/hi valid only while done=1.
// Backpressure: none; start is only legal while busy=0 (guaranteed by the caller).
// Ports   : clk, rst, start, mode, a, b in; busy, done, lo (low/quotient), hi (high/remainder) out.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_mode_t        mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic              is_div;
  logic              neg_q;
  logic              neg_r;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;

  // Operand magnitudes for signed division; the most negative value maps to
  // itself, which is the correct unsigned magnitude.
  always_comb begin
    a_neg = (mode == MD_DIVS) && a[XLEN-1];
    b_neg = (mode == MD_DIVS) && b[XLEN-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  // The last step finishes on the same edge the top level captures the
  // answer, so the outputs are taken from the next-state accumulator.
  assign done = busy && (cnt == CW'(XLEN - 1));

  always_comb begin
    // Multiply: acc = {partial, multiplier}; add on LSB, shift right.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend}; shift left keeping the bit that
    // leaves the remainder, since unsigned divisors can exceed 2^(XLEN-1).
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    rem_ge  = (rem_sh >= {1'b0, opnd});
    rem_new = rem_ge ? (rem_sh[XLEN-1:0] - opnd) : rem_sh[XLEN-1:0];
    div_nxt = {rem_new, acc[XLEN-2:0], rem_ge};

    acc_nxt = is_div ? div_nxt : mul_nxt;
    quo     = acc_nxt[XLEN-1:0];
    rmd     = acc_nxt[2*XLEN-1:XLEN];

    lo = '0;
    hi = '0;
    if (done) begin
      lo = (is_div && neg_q) ? -quo : quo;
      hi = (is_div && neg_r) ? -rmd : rmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      is_div <= (mode != MD_MUL);
      if (mode == MD_MUL) begin
        acc   <= {{XLEN{1'b0}}, b};
        opnd  <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        acc   <= {{XLEN{1'b0}}, mag_a};
        opnd  <= mag_b;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iterative_md.sv
// Purpose : execute-stage ALU: 1-cycle integer ops plus iterative MUL/MULHU/DIV/DIVU/REM/REMU.
// Latency : done at T+1 for simple ops and div fast-path cases, T+XLEN+1 for iterative ops.
// Backpressure: ready=1 only in IDLE; start while ready=0 is dropped (no queueing).
// Ports   : clk, rst (sync, active-high); bus (slave): start/ALUControl/a/b in,
//           ready/done/result/z/n/v/c/illegal out (result, flags, illegal registered).
module alu_iterative_md
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  alu_iterative_md_if.slave   bus
);

  localparam int               SW    = $clog2(XLEN);
  localparam logic [XLEN-1:0]  A_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  state_t          state_nxt;
  logic            ready_w;
  logic            done_w;

  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [SW-1:0]   shamt;

  logic            accept;
  logic            is_divrem;
  logic            b_zero;
  logic            div_ovf;
  logic            fast;
  logic            start_iter;
  md_mode_t        md_mode;

  logic [XLEN:0]   add_full;
  logic [XLEN:0]   sub_full;
  logic [XLEN-1:0] res_imm;
  logic            c_imm;
  logic            v_imm;
  logic            ill_imm;

  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_lo;
  logic [XLEN-1:0] md_hi;
  logic [XLEN-1:0] md_res;
  logic            sel_hi_q;

  logic [XLEN-1:0] result_q;
  logic            z_q;
  logic            n_q;
  logic            v_q;
  logic            c_q;
  logic            illegal_q;

  assign op    = bus.ALUControl;
  assign a     = bus.a;
  assign b     = bus.b;
  assign shamt = b[SW-1:0];

  assign accept    = bus.start && ready_w;
  assign is_divrem = op[3] & op[2];
  assign b_zero    = (b == '0);
  assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == A_MIN) && (b == '1);
  // Divide corner cases are resolved at accept and never enter CALC.
  assign fast       = is_divrem && (b_zero || div_ovf);
  assign start_iter = accept && MULDIV_EN && is_md_op(op) && !fast;

  always_comb begin
    md_mode = MD_DIVU;
    if ((op == OP_MUL) || (op == OP_MULHU)) begin
      md_mode = MD_MUL;
    end else if ((op == OP_DIV) || (op == OP_REM)) begin
      md_mode = MD_DIVS;
    end
  end

  // Single-cycle results and fast-path answers.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (XLEN + 1)'(1);
    res_imm  = '0;
    c_imm    = 1'b0;
    v_imm    = 1'b0;
    ill_imm  = 1'b0;
    case (op)
      OP_ADD: begin
        res_imm = add_full[XLEN-1:0];
        c_imm   = add_full[XLEN];
        v_imm   = (a[XLEN-1] == b[XLEN-1]) && (add_full[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        res_imm = sub_full[XLEN-1:0];
        c_imm   = sub_full[XLEN];   // 1 = no borrow
        v_imm   = (a[XLEN-1] != b[XLEN-1]) && (sub_full[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:  res_imm = a & b;
      OP_OR:   res_imm = a | b;
      OP_XOR:  res_imm = a ^ b;
      OP_SLT:  res_imm = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_imm = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL:  res_imm = a << shamt;
      OP_SRL:  res_imm = a >> shamt;
      OP_SRA:  res_imm = $unsigned($signed(a) >>> shamt);
      default: begin
        if (!MULDIV_EN) begin
          ill_imm = 1'b1;
        end else if (b_zero) begin
          res_imm = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
        end else if (div_ovf) begin
          res_imm = (op == OP_DIV) ? a : '0;
        end
      end
    endcase
  end

  alu_seq_muldiv #(
    .XLEN (XLEN)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (start_iter),
    .mode  (md_mode),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  assign md_res = sel_hi_q ? md_hi : md_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_w   = 1'b0;
    done_w    = 1'b0;
    case (state)
      IDLE: begin
        ready_w = 1'b1;
        if (accept) begin
          state_nxt = start_iter ? CALC : DONE;
        end
      end
      CALC: begin
        if (md_done) begin
          state_nxt = DONE;
        end else if (!md_busy) begin
          // Sequencer idle without finishing: do not hang the pipeline.
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done_w    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      z_q       <= 1'b1;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      c_q       <= 1'b0;
      illegal_q <= 1'b0;
      sel_hi_q  <= 1'b0;
    end else if (accept) begin
      sel_hi_q <= (op == OP_MULHU) || (op == OP_REM) || (op == OP_REMU);
      if (!start_iter) begin
        result_q  <= res_imm;
        z_q       <= (res_imm == '0);
        n_q       <= res_imm[XLEN-1];
        v_q       <= v_imm;
        c_q       <= c_imm;
        illegal_q <= ill_imm;
      end
    end else if ((state == CALC) && md_done) begin
      result_q  <= md_res;
      z_q       <= (md_res == '0);
      n_q       <= md_res[XLEN-1];
      v_q       <= 1'b0;
      c_q       <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  assign bus.ready   = ready_w;
  assign bus.done    = done_w;
  assign bus.result  = result_q;
  assign bus.z       = z_q;
  assign bus.n       = n_q;
  assign bus.v       = v_q;
  assign bus.c       = c_q;
  assign bus.illegal = illegal_q;

endmodule
